// File: rtl/twiddle_seq_if.sv
// Handshake bundle between the twiddle sequencer and its stage controller /
// complex-multiplier consumer.
interface twiddle_seq_if #(
  parameter int W    = 8,
  parameter int W1   = 9,
  parameter int LOGN = 4
);
  logic                       start;
  logic [$clog2(LOGN)-1:0]    stage;
  logic                       ready;
  logic                       valid;
  logic [W-1:0]               c_out;
  logic [W1-1:0]              cps_out;
  logic [W1-1:0]              cms_out;
  logic [LOGN-2:0]            tw_idx;
  logic                       last;
  logic                       busy;
  logic                       done;

  modport master (
    input  start, stage, ready,
    output valid, c_out, cps_out, cms_out, tw_idx, last, busy, done
  );

  modport slave (
    output start, stage, ready,
    input  valid, c_out, cps_out, cms_out, tw_idx, last, busy, done
  );
endinterface

// File: rtl/twiddle_seq.sv
// Twiddle-factor sequencer: streams (cos, cos+sin, cos-sin) coefficients for one
// radix-2 DIT FFT stage per start request, stallable through valid/ready.
module twiddle_seq #(
  parameter int W    = 8,
  parameter int W1   = 9,
  parameter int LOGN = 4
) (
  input logic           clk,
  input logic           reset,
  twiddle_seq_if.master tw
);
  localparam int BW = LOGN - 1;
  localparam int SW = $clog2(LOGN);
  localparam int TW = W + 2 * W1;
  localparam logic [BW-1:0] B_LAST = {BW{1'b1}};
  localparam logic [BW-1:0] B_ONE  = {{(BW-1){1'b0}}, 1'b1};

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t        state_r;
  logic [BW-1:0] b_r;
  logic [SW-1:0] stage_r;
  logic          valid_r;
  logic          last_r;
  logic          busy_r;
  logic          done_r;
  logic [W-1:0]  c_r;
  logic [W1-1:0] cps_r;
  logic [W1-1:0] cms_r;
  logic [BW-1:0] idx_r;

  logic [BW-1:0] load_b_s;
  logic [SW-1:0] load_stage_s;
  logic [BW-1:0] load_k_s;
  logic [TW-1:0] load_tw_s;

  // Stage s keeps the low s bits of b and scales them to the N-point index.
  function automatic logic [BW-1:0] twiddle_index(input logic [BW-1:0] b,
                                                  input logic [SW-1:0] s);
    logic [BW-1:0] mask;
    mask = (B_ONE << s) - B_ONE;
    return (b & mask) << (BW - int'(s));
  endfunction

  // Constant table for N=16, A=127, packed as {c, c+s, c-s}.
  function automatic logic [TW-1:0] twiddle_rom(input logic [BW-1:0] k);
    logic [TW-1:0] word;
    case (k)
      3'd0:    word = {8'h7F, 9'h07F, 9'h07F};
      3'd1:    word = {8'h75, 9'h044, 9'h0A6};
      3'd2:    word = {8'h5A, 9'h000, 9'h0B4};
      3'd3:    word = {8'h31, 9'h1BC, 9'h0A6};
      3'd4:    word = {8'h00, 9'h181, 9'h07F};
      3'd5:    word = {8'hCF, 9'h15A, 9'h044};
      3'd6:    word = {8'hA6, 9'h14C, 9'h000};
      3'd7:    word = {8'h8B, 9'h15A, 9'h1BC};
      default: word = {8'h7F, 9'h07F, 9'h07F};
    endcase
    return word;
  endfunction

  // Select the twiddle that the next load will present: b=0 of a new stage, or b+1.
  always_comb begin
    load_b_s     = '0;
    load_stage_s = stage_r;
    if (state_r == IDLE) begin
      load_b_s     = '0;
      load_stage_s = tw.stage;
    end else begin
      load_b_s     = b_r + B_ONE;
      load_stage_s = stage_r;
    end
    load_k_s  = twiddle_index(load_b_s, load_stage_s);
    load_tw_s = twiddle_rom(load_k_s);
  end

  // Stage FSM with registered twiddle outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      b_r     <= '0;
      stage_r <= '0;
      valid_r <= 1'b0;
      last_r  <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      c_r     <= '0;
      cps_r   <= '0;
      cms_r   <= '0;
      idx_r   <= '0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (tw.start) begin
            stage_r <= tw.stage;
            b_r     <= '0;
            {c_r, cps_r, cms_r} <= load_tw_s;
            idx_r   <= load_k_s;
            last_r  <= (load_b_s == B_LAST);
            valid_r <= 1'b1;
            busy_r  <= 1'b1;
            state_r <= RUN;
          end else begin
            state_r <= IDLE;
          end
        end
        RUN: begin
          if (tw.ready && (b_r == B_LAST)) begin
            valid_r <= 1'b0;
            last_r  <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            state_r <= IDLE;
          end else if (tw.ready) begin
            b_r     <= load_b_s;
            {c_r, cps_r, cms_r} <= load_tw_s;
            idx_r   <= load_k_s;
            last_r  <= (load_b_s == B_LAST);
          end else begin
            state_r <= RUN;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign tw.valid   = valid_r;
  assign tw.c_out   = c_r;
  assign tw.cps_out = cps_r;
  assign tw.cms_out = cms_r;
  assign tw.tw_idx  = idx_r;
  assign tw.last    = last_r;
  assign tw.busy    = busy_r;
  assign tw.done    = done_r;
endmodule

// File: doc/twiddle_seq.md
# twiddle_seq

Twiddle-factor sequencer for the radix-2 DIT FFT datapath. It sits directly upstream of the 3-multiplier complex multiplier and supplies that multiplier's coefficient inputs: cos, cos+sin and cos−sin. For each FFT stage it issues one twiddle per butterfly in butterfly order from an internal constant table. A valid/ready handshake lets the multiplier side stall the sequence.

## Interface
- W, 8: coefficient bit width (c_out), two's complement, amplitude A = 2^(W-1)-1 = 127
- W1, 9: width of cps_out/cms_out (W+1, absorbs c±s growth)
- LOGN, 4: log2 FFT length; N = 16, N/2 = 8 butterflies per stage

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- start  in  1  one-cycle request to run one stage; ignored while busy=1
- stage  in  2  stage index s (0..LOGN-1), sampled with start
- ready  in  1  downstream accepts current twiddle
- valid  out  1  c_out/cps_out/cms_out/tw_idx hold a valid twiddle
- c_out  out  W  c = round(A·cos(2πk/N))
- cps_out  out  W1  c + s, signed
- cms_out  out  W1  c − s, signed
- tw_idx  out  LOGN-1  twiddle index k of current output
- last  out  1  current output is butterfly N/2-1 of the stage
- busy  out  1  stage in progress
- done  out  1  one-cycle pulse after final handshake of a stage

## Operation
- Twiddle W_N^k = c + j·s with s = round(−A·sin(2πk/N)), k = 0..N/2-1.
- Table, N=16, k:(c,s): 0:(127,0) 1:(117,−49) 2:(90,−90) 3:(49,−117) 4:(0,−127) 5:(−49,−117) 6:(−90,−90) 7:(−117,−49).
- cps/cms are precomputed constants in the table, sign-extended to W1 bits; no runtime adders on the coefficient path.
- Butterfly counter b is LOGN-1 bits. Stage s uses k = (b & (2^s−1)) << (LOGN-1-s):
  - s=0: all k=0
  - s=3: k=b
- FSM states:
  - IDLE: start=1 → latch stage, b=0, load table[k(0)] into output regs, valid=1, busy=1 → RUN.
  - RUN: valid=1 && ready=1 with b≠N/2-1 → b+1, load next twiddle, stay in RUN.
  - RUN: valid=1 && ready=1 with b=N/2-1 → valid=0, busy=0, done=1 for one cycle → IDLE.
  - RUN: ready=0 → all outputs and b hold.
- last = valid && (b == N/2-1). All outputs are registered; no combinational path from ready to the outputs.
- start while busy=1 is ignored, including in the cycle of the final handshake. The stage input is not re-sampled during RUN.
- Reset: asynchronous clear to IDLE. Reset values: valid=0, c_out=0, cps_out=0, cms_out=0, tw_idx=0, last=0, busy=0, done=0. Applies mid-stage with no partial completion and no done pulse.

## Timing
- start sampled at edge t → valid=1 with b=0 twiddle after edge t (latency 1).
- ready held high: one twiddle per cycle; a stage takes N/2 = 8 cycles.
- The final handshake at edge t' gives valid=0, busy=0, done=1 after t'. done drops after t'+1.
- The earliest new start is sampled at edge t'+1, so there is 1 idle cycle between stages at minimum.
- The downstream complex multiplier registers its output one cycle after it consumes a twiddle. This block does not track that latency.

## Test plan
- Reset, then stage=3, start, ready=1 → 8 outputs k=0..7:
  - b=1: c=117, cps=68, cms=166
  - b=4: c=0, cps=−127, cms=127
  - b=6: c=−90, cps=−180, cms=0
  - last=1 only on b=7; done pulse 1 cycle after the b=7 transfer.
- stage=0 → 8 outputs all c=127, cps=127, cms=127, tw_idx=0. stage=1 → tw_idx 0,4,0,4,0,4,0,4. stage=2 → 0,2,4,6,0,2,4,6.
- Backpressure, stage=3: ready=0 for 3 cycles at b=2 → c=90, cps=0, cms=180 and tw_idx=2 held stable, valid=1. Resume → b=3 (c=49, cps=−68, cms=166).
- start pulsed at b=3, and again in the final-handshake cycle → both ignored: sequence unchanged, single done pulse.
- Assert reset asynchronously (between edges) at b=5 → all outputs 0 immediately, no done pulse. A subsequent start runs a full stage from b=0.
- Back-to-back stages: start the next stage the cycle after done → valid=1 again 1 cycle later with b=0 twiddle of the new stage.
